// File: rtl/spi_reg_write_ctrl.sv
// spi_reg_write_ctrl
//   SPI mode-0 initiator that sends one 16-bit register-write frame per
//   accepted start request. The frame is sent MSB first as
//   {1'b1, addr[6:0], data[7:0]}. SCLK = f_clk / (2*CLK_DIV).
//
// Ports
//   clk      in   system clock, all state on the rising edge
//   rst      in   asynchronous active-high reset
//   start    in   frame request, accepted only while idle
//   wr_addr  in   7-bit register address, captured on accept
//   wr_data  in   8-bit register data, captured on accept
//   busy     out  high from the cycle after accept until the gap completes
//   done     out  one-cycle pulse on return to idle
//   sclk     out  SPI clock, idles low
//   ncs      out  chip select, active low, idles high
//   copi     out  serial data to the peripheral
//
// state  | meaning
// IDLE   | ncs high, waiting for start
// SETUP  | ncs low, copi holds bit 15 for CLK_DIV cycles before the first rise
// SHIFT  | 16 bit periods of CLK_DIV high + CLK_DIV low
// GAP    | ncs high for CLK_DIV cycles before the next frame may begin

module spi_reg_write_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [15:0]      shift_reg;
    logic             div_tc;

    assign div_tc = (div_cnt == DIV_LAST);

    // copi is the top bit of the shift register, so it stays a registered
    // output; the register is cleared whenever ncs is high so copi idles low.
    assign copi = shift_reg[15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sclk      <= 1'b0;
            ncs       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg <= {1'b1, wr_addr, wr_data};
                        ncs       <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        state   <= ST_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            sclk <= 1'b0;
                            // The last bit stays on copi through its low phase.
                            if (bit_cnt != 4'd15) begin
                                shift_reg <= {shift_reg[14:0], 1'b0};
                            end
                        end else if (bit_cnt == 4'd15) begin
                            ncs       <= 1'b1;
                            shift_reg <= '0;
                            state     <= ST_GAP;
                        end else begin
                            sclk    <= 1'b1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_write_ctrl.sv
module tb_spi_reg_write_ctrl;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy, done, sclk, ncs, copi;

    spi_reg_write_ctrl #(.CLK_DIV(H)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .sclk    (sclk),
        .ncs     (ncs),
        .copi    (copi)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Line monitor, sampled on falling clock edges.
    logic        prev_sclk, prev_ncs;
    logic [15:0] cur_word;
    logic [15:0] words[$];
    int phase_len, ncs_high, busy_cyc, dones, rises, rises_frame;
    int bad_phase, setup_len, gap_len, nstart;

    task automatic reset_stats();
        prev_sclk = sclk;
        prev_ncs = ncs;
        cur_word = '0;
        words.delete();
        phase_len = 0; ncs_high = 0; busy_cyc = 0; dones = 0; rises = 0;
        rises_frame = 0; bad_phase = 0; setup_len = -1; gap_len = -1; nstart = 0;
    endtask

    task automatic sample();
        if (busy) busy_cyc++;
        if (done) dones++;
        if (prev_ncs && !ncs) begin
            if (nstart > 0) gap_len = ncs_high;
            nstart++;
            phase_len = 1;
            cur_word = '0;
            rises_frame = 0;
        end else if (!prev_ncs && ncs) begin
            if (phase_len != H) bad_phase++;
            words.push_back(cur_word);
            ncs_high = 1;
        end else if (ncs) begin
            ncs_high++;
        end else if (sclk != prev_sclk) begin
            if (sclk) begin
                if (rises_frame == 0) setup_len = phase_len;
                else if (phase_len != H) bad_phase++;
                cur_word = {cur_word[14:0], copi};
                rises++;
                rises_frame++;
            end else if (phase_len != H) begin
                bad_phase++;
            end
            phase_len = 1;
        end else begin
            phase_len++;
        end
        prev_sclk = sclk;
        prev_ncs = ncs;
    endtask

    // One frame; optionally a second start with other operands arrives mid-frame.
    task automatic run_frame(input logic [6:0] a, input logic [7:0] d, input bit inject);
        @(negedge clk);
        reset_stats();
        start = 1'b1; wr_addr = a; wr_data = d;
        for (int cyc = 0; cyc < 160; cyc++) begin
            @(negedge clk);
            sample();
            start = inject && (cyc == 40);
            wr_addr = inject ? 7'h12 : ~a;
            wr_data = inject ? 8'h34 : ~d;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  a;
        logic [7:0]  d;
        bit          inject;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 7'h00, d: 8'hA5, inject: 1'b0, exp_word: 16'h80A5};
        vecs[1] = '{a: 7'h00, d: 8'hA5, inject: 1'b1, exp_word: 16'h80A5};
        vecs[2] = '{a: 7'h7F, d: 8'hFF, inject: 1'b0, exp_word: 16'hFFFF};
        vecs[3] = '{a: 7'h55, d: 8'h00, inject: 1'b0, exp_word: 16'hD500};
        vecs[4] = '{a: 7'h2A, d: 8'hC3, inject: 1'b0, exp_word: 16'hAAC3};
        vecs[5] = '{a: 7'h01, d: 8'h5A, inject: 1'b0, exp_word: 16'h815A};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_ncs",  int'(ncs),  1);
        chk("rst_copi", int'(copi), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;

        // Table-driven single frames
        foreach (vecs[i]) begin
            run_frame(vecs[i].a, vecs[i].d, vecs[i].inject);
            chk($sformatf("v%0d_word", i), words.size() == 1 ? int'(words[0]) : -1, int'(vecs[i].exp_word));
            chk($sformatf("v%0d_rises", i), rises, 16);
            chk($sformatf("v%0d_busy", i), busy_cyc, 34 * H);
            chk($sformatf("v%0d_dones", i), dones, 1);
            chk($sformatf("v%0d_badphase", i), bad_phase, 0);
            chk($sformatf("v%0d_setup", i), setup_len, H);
        end

        // Reset after the 5th rising edge, then a clean frame
        @(negedge clk);
        reset_stats();
        start = 1'b1; wr_addr = 7'h10; wr_data = 8'h77;
        for (int cyc = 0; cyc < 200 && rises < 5; cyc++) begin
            @(negedge clk);
            sample();
            start = 1'b0;
        end
        chk("abort_rises", rises, 5);
        #2 rst = 1'b1;
        #1;
        chk("abort_sclk", int'(sclk), 0);
        chk("abort_ncs",  int'(ncs),  1);
        chk("abort_copi", int'(copi), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_no_done", dones, 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(7'h01, 8'h5A, 1'b0);
        chk("post_rst_word", words.size() == 1 ? int'(words[0]) : -1, 16'h815A);
        chk("post_rst_dones", dones, 1);

        // Back-to-back frames with start held
        @(negedge clk);
        reset_stats();
        start = 1'b1; wr_addr = 7'h02; wr_data = 8'h11;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            sample();
            wr_addr = 7'h03; wr_data = 8'h22;
            if (nstart >= 2) start = 1'b0;
        end
        start = 1'b0;
        chk("b2b_nframes", words.size(), 2);
        chk("b2b_word0", words.size() >= 1 ? int'(words[0]) : -1, 16'h8211);
        chk("b2b_word1", words.size() >= 2 ? int'(words[1]) : -1, 16'h8322);
        chk("b2b_gap", gap_len, H + 1);
        chk("b2b_dones", dones, 2);
        chk("b2b_busy", busy_cyc, 2 * 34 * H);
        chk("b2b_rises", rises, 32);
        chk("b2b_badphase", bad_phase, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
